tiny_dnn_ex_acc: RTL

- Multiply-accumulate and output stage that sits directly downstream of the execution controller.
- Consumes the controller's exec, k_init and k_fin strobes, plus input and weight words read from the buffers at ia/wa; the buffers have 1-cycle read latency.
- Accumulates one output pixel per kernel pass, adds bias, optionally applies ReLU, saturates and queues the result in a small FIFO drained by the writeback stream.
- Returns out_busy and outr to the controller for backpressure and end-of-step hold.

---
 rtl/tiny_dnn_pkg.sv | 24 ++
 rtl/tiny_dnn_out_fifo.sv | 60 ++++++
 rtl/tiny_dnn_ex_acc.sv | 111 +++++++++++
 3 files changed

// File: rtl/tiny_dnn_pkg.sv
// Shared defaults and fixed-point helpers for the tiny_dnn execution datapath.
package tiny_dnn_pkg;

    localparam int DW_DEF    = 16;
    localparam int AW_DEF    = 40;
    localparam int FRAC_DEF  = 8;
    localparam int DEPTH_DEF = 4;

    // Clamp a signed value into the range representable by a w-bit signed word.
    function automatic logic signed [63:0] sat(input logic signed [63:0] x, input int w);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (w - 1));
        if (x > hi) begin
            return hi;
        end else if (x < lo) begin
            return lo;
        end else begin
            return x;
        end
    endfunction

endpackage

// File: rtl/tiny_dnn_out_fifo.sv
// Circular result FIFO between the MAC output stage and the writeback stream.
module tiny_dnn_out_fifo #(
    parameter int W     = 16,
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic [W-1:0]  wdata,
    input  logic          pop,
    output logic [W-1:0]  rdata,
    output logic [CW-1:0] count,
    output logic [CW-1:0] count_next,
    output logic          full,
    output logic          empty
);
    localparam int PW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          wr_en, rd_en;

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);
    // A push into a full FIFO only lands if a pop frees the slot in the same cycle.
    assign wr_en = push && (!full || pop);
    assign rd_en = pop && !empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_en) wr_ptr_d = wr_ptr_q + PW'(1);
        if (rd_en) rd_ptr_d = rd_ptr_q + PW'(1);
        if (wr_en && !rd_en) count_d = count_q + CW'(1);
        else if (rd_en && !wr_en) count_d = count_q - CW'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            if (wr_en) mem_q[wr_ptr_q] <= wdata;
        end
    end

    assign rdata      = mem_q[rd_ptr_q];
    assign count      = count_q;
    assign count_next = count_d;

endmodule

// File: rtl/tiny_dnn_ex_acc.sv
// Multiply-accumulate, bias/ReLU/saturate output stage and result queue fed by the execution controller.
module tiny_dnn_ex_acc
    import tiny_dnn_pkg::*;
#(
    parameter int DW    = DW_DEF,
    parameter int AW    = AW_DEF,
    parameter int FRAC  = FRAC_DEF,
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          backprop,
    input  logic          relu,
    input  logic          k_init,
    input  logic          exec,
    input  logic          k_fin,
    input  logic [DW-1:0] d,
    input  logic [DW-1:0] w,
    input  logic [DW-1:0] bias,
    output logic          out_busy,
    output logic          outr,
    output logic          m_valid,
    input  logic          m_ready,
    output logic [DW-1:0] m_data,
    output logic          ovf
);
    localparam int CW = $clog2(DEPTH + 1);

    logic                 v1_q, fin1_q, push_q, busy_q, ovf_q;
    logic                 busy_d, ovf_d;
    logic signed [AW-1:0] acc_q, acc_d;
    logic [DW-1:0]        bias_q, bias_d;
    logic [DW-1:0]        res_q, res_d;

    logic signed [2*DW-1:0] prod;
    logic signed [AW-1:0]   prod_ext, bias_term, s, r;
    logic signed [63:0]     r_sat;
    logic [DW-1:0]          res_val;

    logic          pop, fifo_full, fifo_empty;
    logic [CW-1:0] fifo_count, fifo_count_next;

    assign pop = m_valid && m_ready;

    // The result is formed from the current acc/bias registers, so a k_init in the
    // fin1 cycle can clear them for the next pass without disturbing this one.
    always_comb begin
        prod      = $signed(d) * $signed(w);
        prod_ext  = AW'(prod);
        bias_term = backprop ? '0 : (AW'($signed(bias_q)) <<< FRAC);
        s         = acc_q + bias_term;
        r         = s >>> FRAC;
        r_sat     = sat(64'(r), DW);
        res_val   = DW'(r_sat);
        if (relu && !backprop && res_val[DW-1]) res_val = '0;

        acc_d = acc_q;
        if (k_init) acc_d = '0;
        else if (v1_q) acc_d = acc_q + prod_ext;

        bias_d = k_init ? bias : bias_q;
        res_d  = fin1_q ? res_val : res_q;
        ovf_d  = ovf_q | (push_q & fifo_full & ~pop);
        busy_d = (fifo_count_next >= CW'(DEPTH - 2));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_q   <= 1'b0;
            fin1_q <= 1'b0;
            push_q <= 1'b0;
            busy_q <= 1'b0;
            ovf_q  <= 1'b0;
            acc_q  <= '0;
            bias_q <= '0;
            res_q  <= '0;
        end else begin
            v1_q   <= exec;
            fin1_q <= k_fin;
            push_q <= fin1_q;
            busy_q <= busy_d;
            ovf_q  <= ovf_d;
            acc_q  <= acc_d;
            bias_q <= bias_d;
            res_q  <= res_d;
        end
    end

    tiny_dnn_out_fifo #(
        .W     (DW),
        .DEPTH (DEPTH),
        .CW    (CW)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (push_q),
        .wdata      (res_q),
        .pop        (pop),
        .rdata      (m_data),
        .count      (fifo_count),
        .count_next (fifo_count_next),
        .full       (fifo_full),
        .empty      (fifo_empty)
    );

    assign m_valid  = !fifo_empty;
    assign outr     = v1_q | fin1_q | push_q | (fifo_count != '0);
    assign out_busy = busy_q;
    assign ovf      = ovf_q;

endmodule
